bounce_key_sender: RTL and testbench

Initiator side of the BounceFSM lock interface. Holds a programmable code of up to seven 4-bit digits and plays it into the lock one digit at a time, driving chip-enable, data and set-data strobe. After each digit it waits for that digit's acknowledge bit, then checks the unlock bit, and reports success, or failure on timeout. It sits in front of the lock in the same top level and drives the lock's `i_CE`, `i_set_data` and `iv_data` inputs; its `iv_acknowledge` port takes the lock's `o_acknowledge` output.

---
 rtl/bounce_key_sender.sv | 187 ++++++++++++++++++
 tb/tb_bounce_key_sender.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_key_sender.sv
// Initiator for the BounceFSM lock: plays a stored code of up to seven 4-bit
// digits into the lock, waits for each digit's acknowledge, then for unlock.
module bounce_key_sender #(
    parameter int N_DIGITS      = 7,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic       clk,
    input  logic       i_Rst,
    input  logic       i_start,
    input  logic       i_code_wr_en,
    input  logic [2:0] iv_code_wr_addr,
    input  logic [3:0] iv_code_wr_data,
    input  logic [7:0] iv_acknowledge,
    output logic       o_CE,
    output logic       o_set_data,
    output logic [3:0] ov_data,
    output logic       o_busy,
    output logic       o_unlocked,
    output logic       o_fail,
    output logic [2:0] ov_fail_idx
);

    // state        | meaning
    // S_IDLE       | reset state, outputs quiet, waiting for i_start
    // S_SETUP      | CE up, digit k presented, strobe low (1 cycle)
    // S_STROBE     | set_data high for STROBE_CYCLES
    // S_WAIT_ACK   | waiting for iv_acknowledge[k], bounded by TIMEOUT
    // S_GAP        | idle GAP_CYCLES before the next digit
    // S_WAIT_UNLOCK| waiting for iv_acknowledge[7], bounded by TIMEOUT
    // S_DONE       | lock opened, o_unlocked sticky until next start
    // S_FAIL       | an acknowledge timed out, o_fail and ov_fail_idx held
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT_ACK,
        S_GAP,
        S_WAIT_UNLOCK,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [7:0] STROBE_LAST  = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST     = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] LAST_K       = 3'(N_DIGITS - 1);

    state_t     r_state;
    logic [2:0] r_k;
    logic [7:0] r_timer;
    logic [3:0] r_code [0:6];

    logic       r_ce;
    logic       r_set_data;
    logic [3:0] r_data;
    logic       r_busy;
    logic       r_unlocked;
    logic       r_fail;
    logic [2:0] r_fail_idx;

    state_t     w_next_state;
    logic [2:0] w_next_k;
    logic [7:0] w_next_timer;
    logic [2:0] w_next_fail_idx;
    logic       w_next_active;
    logic       w_next_shows_digit;
    logic [3:0] w_next_data;

    // Code writes are dropped while a sequence is playing so the digits
    // presented to the lock never change mid-sequence.
    always_ff @(posedge clk or negedge i_Rst) begin
        if (!i_Rst) begin
            for (int i = 0; i < 7; i++) begin
                r_code[i] <= '0;
            end
        end else if (i_code_wr_en && !r_busy && (iv_code_wr_addr != 3'd7)) begin
            r_code[iv_code_wr_addr] <= iv_code_wr_data;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_k        = r_k;
        w_next_fail_idx = r_fail_idx;

        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (i_start) begin
                    w_next_state    = S_SETUP;
                    w_next_k        = 3'd0;
                    w_next_fail_idx = 3'd0;
                end
            end
            S_SETUP: begin
                w_next_state = S_STROBE;
            end
            S_STROBE: begin
                if (r_timer == STROBE_LAST) begin
                    w_next_state = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // An ack in the last allowed wait cycle still wins over the timeout.
                if (iv_acknowledge[r_k]) begin
                    w_next_state = (r_k < LAST_K) ? S_GAP : S_WAIT_UNLOCK;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_next_state    = S_FAIL;
                    w_next_fail_idx = r_k;
                end
            end
            S_GAP: begin
                if (r_timer == GAP_LAST) begin
                    w_next_state = S_SETUP;
                    w_next_k     = r_k + 3'd1;
                end
            end
            S_WAIT_UNLOCK: begin
                if (iv_acknowledge[7]) begin
                    w_next_state = S_DONE;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_next_state    = S_FAIL;
                    w_next_fail_idx = 3'd7;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (w_next_state != r_state) begin
            w_next_timer = 8'd0;
        end else if ((r_state == S_STROBE) || (r_state == S_WAIT_ACK) ||
                     (r_state == S_GAP) || (r_state == S_WAIT_UNLOCK)) begin
            w_next_timer = r_timer + 8'd1;
        end else begin
            w_next_timer = r_timer;
        end

        w_next_active = (w_next_state == S_SETUP) || (w_next_state == S_STROBE) ||
                        (w_next_state == S_WAIT_ACK) || (w_next_state == S_GAP) ||
                        (w_next_state == S_WAIT_UNLOCK);

        w_next_shows_digit = (w_next_state == S_SETUP) || (w_next_state == S_STROBE) ||
                             (w_next_state == S_WAIT_ACK) || (w_next_state == S_GAP);

        w_next_data = w_next_shows_digit ? r_code[w_next_k] : 4'd0;
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_timer    <= '0;
            r_ce       <= 1'b0;
            r_set_data <= 1'b0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_unlocked <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_idx <= '0;
        end else begin
            r_state    <= w_next_state;
            r_k        <= w_next_k;
            r_timer    <= w_next_timer;
            r_ce       <= w_next_active;
            r_set_data <= (w_next_state == S_STROBE);
            r_data     <= w_next_data;
            r_busy     <= w_next_active;
            r_unlocked <= (w_next_state == S_DONE);
            r_fail     <= (w_next_state == S_FAIL);
            r_fail_idx <= w_next_fail_idx;
        end
    end

    assign o_CE        = r_ce;
    assign o_set_data  = r_set_data;
    assign ov_data     = r_data;
    assign o_busy      = r_busy;
    assign o_unlocked  = r_unlocked;
    assign o_fail      = r_fail;
    assign ov_fail_idx = r_fail_idx;

endmodule

// File: tb/tb_bounce_key_sender.sv
// Directed bench for bounce_key_sender: a scenario table driven against a small
// lock model, plus hand-written reset and busy-lockout sequences.
module tb_bounce_key_sender;

    logic       clk = 1'b0;
    logic       i_Rst;
    logic       i_start;
    logic       i_code_wr_en;
    logic [2:0] iv_code_wr_addr;
    logic [3:0] iv_code_wr_data;
    logic [7:0] iv_acknowledge;
    logic       o_CE;
    logic       o_set_data;
    logic [3:0] ov_data;
    logic       o_busy;
    logic       o_unlocked;
    logic       o_fail;
    logic [2:0] ov_fail_idx;

    bounce_key_sender dut (
        .clk             (clk),
        .i_Rst           (i_Rst),
        .i_start         (i_start),
        .i_code_wr_en    (i_code_wr_en),
        .iv_code_wr_addr (iv_code_wr_addr),
        .iv_code_wr_data (iv_code_wr_data),
        .iv_acknowledge  (iv_acknowledge),
        .o_CE            (o_CE),
        .o_set_data      (o_set_data),
        .ov_data         (ov_data),
        .o_busy          (o_busy),
        .o_unlocked      (o_unlocked),
        .o_fail          (o_fail),
        .ov_fail_idx     (ov_fail_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lock model: acks digit k two cycles after its strobe falls, and raises
    // ack[7] together with the last digit's ack.
    bit         force_ff   = 1'b0;
    int         skip_digit = -1;
    bit         no_unlock  = 1'b0;
    logic [7:0] lock_ack   = 8'h00;
    int         lk_falls   = 0;
    int         lk_pend    = 0;
    int         lk_idx     = 0;
    logic       lk_prev    = 1'b0;

    assign iv_acknowledge = force_ff ? 8'hFF : lock_ack;

    always @(negedge clk) begin
        if (!o_busy) begin
            lock_ack = 8'h00;
            lk_falls = 0;
            lk_pend  = 0;
            lk_prev  = 1'b0;
        end else begin
            if (lk_pend > 0) begin
                lk_pend--;
                if (lk_pend == 0 && lk_idx != skip_digit) begin
                    lock_ack[lk_idx[2:0]] = 1'b1;
                    if (lk_idx == 6 && !no_unlock) lock_ack[7] = 1'b1;
                end
            end
            if (lk_prev && !o_set_data) begin
                lk_idx  = lk_falls;
                lk_pend = 2;
                lk_falls++;
            end
            lk_prev = o_set_data;
        end
    end

    // Sequence observation results
    int         nd;
    logic [3:0] dig_val   [8];
    int         dig_start [8];
    int         dig_str   [8];
    int         last_fall;
    bit         both_hi;
    logic       g_prev_ce, g_prev_unl, g_prev_fail;

    task automatic write_code(input logic [2:0] addr, input logic [3:0] data);
        i_code_wr_en    = 1'b1;
        iv_code_wr_addr = addr;
        iv_code_wr_data = data;
        @(negedge clk);
        i_code_wr_en    = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Called at the negedge of cycle 1 (SETUP). Returns the first cycle with
    // o_busy low, or -1 if the cycle budget runs out.
    task automatic watch(input int inject, output int end_c);
        logic prev_sd;
        prev_sd = 1'b0; g_prev_ce = 1'b0; g_prev_unl = 1'b0; g_prev_fail = 1'b0;
        nd = 0; last_fall = -1; both_hi = 1'b0; end_c = -1;
        for (int c = 1; c <= 2000; c++) begin
            if (o_unlocked && o_fail) both_hi = 1'b1;
            if (!o_busy) begin
                end_c = c;
                break;
            end
            if (o_set_data && !prev_sd && nd < 8) begin
                dig_val[nd]   = ov_data;
                dig_start[nd] = c;
                dig_str[nd]   = 1;
                nd++;
            end else if (o_set_data && nd > 0) begin
                dig_str[nd-1]++;
            end
            if (!o_set_data && prev_sd) last_fall = c;
            if (c == inject) begin
                i_start         = 1'b1;
                i_code_wr_en    = 1'b1;
                iv_code_wr_addr = 3'd0;
                iv_code_wr_data = 4'h9;
            end else begin
                i_start      = 1'b0;
                i_code_wr_en = 1'b0;
            end
            prev_sd     = o_set_data;
            g_prev_ce   = o_CE;
            g_prev_unl  = o_unlocked;
            g_prev_fail = o_fail;
            @(negedge clk);
        end
        i_start      = 1'b0;
        i_code_wr_en = 1'b0;
    endtask

    typedef struct {
        logic [27:0] code;
        int          skip;
        bit          no_unl;
        bit          ff;
        bit          exp_unl;
        bit          exp_fail;
        logic [2:0]  exp_idx;
        int          exp_nd;
        int          exp_fail_gap;
        int          exp_end;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int end_c;
        logic [27:0] cw;

        //               code        skip nounl ff unl fail idx nd gap  end
        vecs[0] = '{28'hC70F5A3, -1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 7, -1, -1};
        vecs[1] = '{28'hC70F5A3,  3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 4, 255, -1};
        vecs[2] = '{28'h7654321, -1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 7, -1, -1};
        vecs[3] = '{28'h3456789, -1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 7, -1, 42};

        i_Rst = 1'b0; i_start = 1'b0; i_code_wr_en = 1'b0;
        iv_code_wr_addr = 3'd0; iv_code_wr_data = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({o_CE, o_set_data, ov_data, o_busy, o_unlocked, o_fail, ov_fail_idx}), 32'd0);
        i_Rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_outputs", 32'({o_CE, o_set_data, ov_data, o_busy, o_unlocked, o_fail, ov_fail_idx}), 32'd0);

        for (int v = 0; v < 4; v++) begin
            cw = vecs[v].code;
            for (int d = 0; d < 7; d++) write_code(3'(d), cw[4*d +: 4]);
            force_ff   = vecs[v].ff;
            skip_digit = vecs[v].skip;
            no_unlock  = vecs[v].no_unl;
            pulse_start();
            chk("start_flags", 32'({o_busy, o_CE, o_unlocked, o_fail, ov_fail_idx}), 32'b1100000);
            watch(-1, end_c);
            chk("seq_ended", 32'(end_c > 0), 32'd1);
            chk("unlocked", 32'(o_unlocked), 32'(vecs[v].exp_unl));
            chk("fail", 32'(o_fail), 32'(vecs[v].exp_fail));
            chk("fail_idx", 32'(ov_fail_idx), 32'(vecs[v].exp_idx));
            chk("ce_after", 32'(o_CE), 32'd0);
            chk("digit_count", 32'(nd), 32'(vecs[v].exp_nd));
            chk("flags_exclusive", 32'(both_hi), 32'd0);
            for (int d = 0; d < nd && d < 7; d++) begin
                chk("digit_value", 32'(dig_val[d]), 32'(cw[4*d +: 4]));
                chk("strobe_len", 32'(dig_str[d]), 32'd2);
            end
            if (vecs[v].exp_unl) chk("unlock_with_busy_fall", 32'(g_prev_unl), 32'd0);
            if (vecs[v].exp_fail) begin
                chk("fail_with_ce_fall", 32'({g_prev_ce, g_prev_fail}), 32'b10);
            end
            if (vecs[v].exp_fail_gap >= 0)
                chk("timeout_cycles", 32'(end_c - last_fall), 32'(vecs[v].exp_fail_gap));
            if (vecs[v].exp_end > 0) begin
                chk("seq_cycles", 32'(end_c), 32'(vecs[v].exp_end));
                for (int d = 0; d < nd && d < 7; d++)
                    chk("digit_pitch", 32'(dig_start[d]), 32'(2 + 6*d));
            end
            repeat (3) @(negedge clk);
        end

        // Reset during the second strobe cycle of digit 2 (code 9,8,7,...).
        force_ff = 1'b1; skip_digit = -1; no_unlock = 1'b0;
        pulse_start();
        repeat (14) @(negedge clk);
        chk("pre_reset_strobe", 32'({o_CE, o_set_data, ov_data}), 32'({1'b1, 1'b1, 4'h7}));
        #1 i_Rst = 1'b0;
        #1 chk("async_reset", 32'({o_CE, o_set_data, ov_data, o_busy, o_unlocked, o_fail, ov_fail_idx}), 32'd0);
        @(negedge clk);
        i_Rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", 32'({o_CE, o_busy, o_unlocked}), 32'd0);
        pulse_start();
        watch(-1, end_c);
        chk("replay_cycles", 32'(end_c), 32'd42);
        chk("replay_first_digit", 32'(dig_start[0]), 32'd2);
        chk("replay_unlocked", 32'(o_unlocked), 32'd1);
        for (int d = 0; d < nd && d < 7; d++) chk("replay_code_zero", 32'(dig_val[d]), 32'd0);

        // Busy lockout: start and code[0] write mid-sequence are ignored.
        cw = 28'h7654321;
        for (int d = 0; d < 7; d++) write_code(3'(d), cw[4*d +: 4]);
        pulse_start();
        watch(10, end_c);
        chk("lockout_cycles", 32'(end_c), 32'd42);
        chk("lockout_digits", 32'(nd), 32'd7);
        repeat (2) @(negedge clk);
        pulse_start();
        watch(-1, end_c);
        chk("lockout_code0_kept", 32'(dig_val[0]), 32'h1);
        repeat (2) @(negedge clk);
        write_code(3'd0, 4'h9);
        pulse_start();
        watch(-1, end_c);
        chk("idle_write_taken", 32'(dig_val[0]), 32'h9);
        chk("idle_write_other", 32'(dig_val[1]), 32'h2);
        chk("idle_write_done", 32'(o_unlocked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, wanted under 2000000", $time);
        $fatal(1);
    end

endmodule
